// File: rtl/cpu_pkg.sv
// Shared zzcpu definitions: opcodes, NOP encoding, BHT counter states, sign-extension helpers.
package cpu_pkg;

  localparam logic [4:0] OP_B         = 5'b00010;
  localparam logic [4:0] OP_BEQZ      = 5'b00100;
  localparam logic [4:0] OP_BNEZ      = 5'b00101;
  localparam logic [4:0] OP_BTEQZ_GRP = 5'b01100;

  localparam logic [15:0] INSTR_NOP = 16'h0800;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Hazard-unit control and IF/ID pipeline-register bundle between fetch_unit and the ID stage.
interface fetch_unit_if;

  logic        hold_i;
  logic        flush_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        bht_upd_i;
  logic [15:0] bht_upd_pc_i;
  logic        bht_taken_i;

  logic [15:0] instr_o;
  logic [15:0] pc_o;
  logic [15:0] pcplus1_o;
  logic        pred_taken_o;
  logic        valid_o;

  // fetch_unit side
  modport slave (
    input  hold_i, flush_i, redirect_i, redirect_pc_i,
    input  bht_upd_i, bht_upd_pc_i, bht_taken_i,
    output instr_o, pc_o, pcplus1_o, pred_taken_o, valid_o
  );

  // hazard unit / ID side
  modport master (
    output hold_i, flush_i, redirect_i, redirect_pc_i,
    output bht_upd_i, bht_upd_pc_i, bht_taken_i,
    input  instr_o, pc_o, pcplus1_o, pred_taken_o, valid_o
  );

endinterface

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating branch counters with combinational lookup and async clear to WNT.
module branch_history_table
  import cpu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             pred_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int NUM_ENTRIES = 1 << IDX_W;

  logic [NUM_ENTRIES-1:0] pred_bits;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    bht_ctr_t ctr_reg;
    bht_ctr_t ctr_next;

    always_comb begin
      ctr_next = ctr_reg;
      if (upd_taken) begin
        if (ctr_reg != ST) ctr_next = bht_ctr_t'(ctr_reg + 2'd1);
      end else begin
        if (ctr_reg != SNT) ctr_next = bht_ctr_t'(ctr_reg - 2'd1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctr_reg <= WNT;
      end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
        ctr_reg <= ctr_next;
      end
    end

    assign pred_bits[gi] = ctr_reg[1];
  end

  // Lookup sees the pre-update value when reading and writing the same entry.
  assign pred_taken = pred_bits[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// zzcpu instruction fetch: PC, Ram2 read port, IF/ID register, optional branch prediction.
// Prediction (predecode + BHT) is built only when FETCH_BPRED_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.slave   bus,
  output logic [17:0]   Ram2Addr,
  inout  wire  [15:0]   Ram2Data,
  output logic          Ram2OE,
  output logic          Ram2WE,
  output logic          Ram2EN
);

  logic [15:0] pc_reg;
  logic [15:0] pc_next;
  logic [15:0] pc_plus1;
  logic [15:0] fetch_word;
  logic        pred_taken;
  logic [15:0] br_target;

  logic [15:0] instr_reg;
  logic [15:0] epc_reg;
  logic [15:0] pcplus1_reg;
  logic        pred_reg;
  logic        valid_reg;

  assign Ram2Data   = 16'bz;
  assign Ram2EN     = 1'b0;
  assign Ram2OE     = 1'b0;
  assign Ram2WE     = 1'b1;
  assign Ram2Addr   = {2'b00, pc_reg};
  assign fetch_word = Ram2Data;
  assign pc_plus1   = pc_reg + 16'd1;

`ifdef FETCH_BPRED_EN
  logic [4:0] opcode;
  logic       is_b;
  logic       is_cond;
  logic       bht_pred;
  logic       unused_upd_pc;

  assign opcode  = fetch_word[15:11];
  assign is_b    = (opcode == OP_B);
  // BTEQZ/BTNEZ share one opcode; only sub-codes 000/001 are branches.
  assign is_cond = (opcode == OP_BEQZ) || (opcode == OP_BNEZ) ||
                   ((opcode == OP_BTEQZ_GRP) && (fetch_word[10:9] == 2'b00));

  assign br_target = pc_plus1 + (is_b ? sext11(fetch_word[10:0]) : sext8(fetch_word[7:0]));

  branch_history_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (pc_reg[BHT_IDX_W-1:0]),
    .pred_taken (bht_pred),
    .upd_en     (bus.bht_upd_i),
    .upd_idx    (bus.bht_upd_pc_i[BHT_IDX_W-1:0]),
    .upd_taken  (bus.bht_taken_i)
  );

  assign pred_taken    = is_b || (is_cond && bht_pred);
  assign unused_upd_pc = &{1'b0, bus.bht_upd_pc_i[15:BHT_IDX_W]};
`else
  logic unused_bht;

  assign pred_taken = 1'b0;
  assign br_target  = pc_plus1;
  assign unused_bht = &{1'b0, bus.bht_upd_i, bus.bht_upd_pc_i, bus.bht_taken_i};
`endif

  always_comb begin
    pc_next = pc_plus1;
    if (bus.redirect_i) begin
      pc_next = bus.redirect_pc_i;
    end else if (bus.hold_i) begin
      pc_next = pc_reg;
    end else if (pred_taken) begin
      pc_next = br_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= PC_RESET;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Flush outranks hold so a squash still lands while ID is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg   <= INSTR_NOP;
      epc_reg     <= 16'h0000;
      pcplus1_reg <= 16'h0000;
      pred_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (bus.flush_i) begin
      instr_reg   <= INSTR_NOP;
      epc_reg     <= 16'h0000;
      pcplus1_reg <= 16'h0000;
      pred_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else if (!bus.hold_i) begin
      instr_reg   <= fetch_word;
      epc_reg     <= pc_reg;
      pcplus1_reg <= pc_plus1;
      pred_reg    <= pred_taken;
      valid_reg   <= 1'b1;
    end
  end

  assign bus.instr_o      = instr_reg;
  assign bus.pc_o         = epc_reg;
  assign bus.pcplus1_o    = pcplus1_reg;
  assign bus.pred_taken_o = pred_reg;
  assign bus.valid_o      = valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  logic [17:0] ram2_addr;
  wire  [15:0] ram2_data;
  logic        ram2_oe;
  logic        ram2_we;
  logic        ram2_en;

  logic [15:0] mem [0:65535];
  assign ram2_data = mem[ram2_addr[15:0]];

  fetch_unit #(
    .PC_RESET  (16'h0000),
    .BHT_IDX_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .Ram2Addr (ram2_addr),
    .Ram2Data (ram2_data),
    .Ram2OE   (ram2_oe),
    .Ram2WE   (ram2_we),
    .Ram2EN   (ram2_en)
  );

`ifdef FETCH_BPRED_EN
  localparam bit BPRED = 1'b1;
`else
  localparam bit BPRED = 1'b0;
`endif

  localparam logic [67:0] RESET_VEC = {18'h0, 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0};

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  int          m_pc;
  logic [15:0] m_instr;
  int          m_epc;
  int          m_pcp1;
  bit          m_pred;
  bit          m_valid;
  int          m_bht [16];

  function automatic logic [67:0] exp_vec();
    return {2'b00, 16'(m_pc), m_instr, 16'(m_epc), 16'(m_pcp1), m_pred, m_valid};
  endfunction

  function automatic logic [67:0] dut_vec();
    return {ram2_addr, bus.instr_o, bus.pc_o, bus.pcplus1_o, bus.pred_taken_o, bus.valid_o};
  endfunction

  task automatic model_reset();
    m_pc    = 0;
    m_instr = 16'h0800;
    m_epc   = 0;
    m_pcp1  = 0;
    m_pred  = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
  endtask

  // Drive one cycle of control inputs, advance the model, clock, then sample point.
  task automatic step(input bit hold, input bit flush, input bit redir, input int rpc,
                      input bit upd, input int upd_pc, input bit taken);
    logic [15:0] w;
    int off, tgt, idx, npc;
    bit is_b, is_c, pred;
    bus.hold_i        = hold;
    bus.flush_i       = flush;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = 16'(rpc);
    bus.bht_upd_i     = upd;
    bus.bht_upd_pc_i  = 16'(upd_pc);
    bus.bht_taken_i   = taken;

    w    = mem[m_pc];
    is_b = (w[15:11] == 5'b00010);
    is_c = (w[15:11] == 5'b00100) || (w[15:11] == 5'b00101) ||
           ((w[15:11] == 5'b01100) && (w[10:8] <= 3'd1));
    off = 0;
    if (is_b) begin
      off = int'(w[10:0]);
      if (off >= 1024) off -= 2048;
    end else if (is_c) begin
      off = int'(w[7:0]);
      if (off >= 128) off -= 256;
    end
    tgt  = (m_pc + 1 + off + 65536) % 65536;
    pred = BPRED && (is_b || (is_c && (m_bht[m_pc % 16] >= 2)));

    if (redir)      npc = rpc % 65536;
    else if (hold)  npc = m_pc;
    else if (pred)  npc = tgt;
    else            npc = (m_pc + 1) % 65536;

    if (flush) begin
      m_instr = 16'h0800; m_epc = 0; m_pcp1 = 0; m_pred = 1'b0; m_valid = 1'b0;
    end else if (!hold) begin
      m_instr = w; m_epc = m_pc; m_pcp1 = (m_pc + 1) % 65536; m_pred = pred; m_valid = 1'b1;
    end

    if (BPRED && upd) begin
      idx = upd_pc % 16;
      if (taken && m_bht[idx] < 3) m_bht[idx] = m_bht[idx] + 1;
      else if (!taken && m_bht[idx] > 0) m_bht[idx] = m_bht[idx] - 1;
    end
    m_pc = npc;

    @(posedge clk);
    #1;
    $display("txn h=%0d f=%0d r=%0d u=%0d addr=%05h instr=%04h epc=%04h pc1=%04h pred=%0d valid=%0d",
             hold, flush, redir, upd, ram2_addr, bus.instr_o, bus.pc_o, bus.pcplus1_o,
             bus.pred_taken_o, bus.valid_o);
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic step_redirect(input int target);
    step(1'b0, 1'b0, 1'b1, target, 1'b0, 0, 1'b0);
  endtask

  task automatic step_train(input int bpc, input bit taken);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, bpc, taken);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_total++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL reset_state: got %h want %h", dut_vec(), RESET_VEC);
    else n_pass++;
    n_total++;
    if ({ram2_oe, ram2_we, ram2_en} !== 3'b010)
      $display("FAIL reset_sram_ctl: got %b want 010", {ram2_oe, ram2_we, ram2_en});
    else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      step_idle();
      n_total++;
      if (ram2_addr !== 18'(i + 1) || bus.pc_o !== 16'(i) || bus.instr_o !== 16'h0800 ||
          bus.valid_o !== 1'b1)
        $display("FAIL seq_%0d: got addr=%h epc=%h instr=%h valid=%b want addr=%h epc=%h instr=0800 valid=1",
                 i, ram2_addr, bus.pc_o, bus.instr_o, bus.valid_o, 18'(i + 1), 16'(i));
      else n_pass++;
    end
    n_total++;
    if ({ram2_oe, ram2_we, ram2_en} !== 3'b010)
      $display("FAIL seq_sram_ctl: got %b want 010", {ram2_oe, ram2_we, ram2_en});
    else n_pass++;
  endtask

  task automatic test_branch_b();
    mem[16'h0010] = 16'h1005;
    step_redirect(16'h0010);
    n_total++;
    if (ram2_addr !== 18'h00010)
      $display("FAIL b_redirect: got addr=%h want 00010", ram2_addr);
    else n_pass++;
    step_idle();
    n_total++;
    if (ram2_addr !== (BPRED ? 18'h00016 : 18'h00011) || bus.pred_taken_o !== BPRED ||
        bus.pc_o !== 16'h0010 || bus.instr_o !== 16'h1005)
      $display("FAIL b_predict: got addr=%h pred=%b epc=%h instr=%h want addr=%h pred=%b epc=0010 instr=1005",
               ram2_addr, bus.pred_taken_o, bus.pc_o, bus.instr_o,
               (BPRED ? 18'h00016 : 18'h00011), BPRED);
    else n_pass++;
    step_idle();
    n_total++;
    if (dut_vec() !== exp_vec())
      $display("FAIL b_after: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_bht_train();
    mem[16'h0020] = 16'h2005;
    step_train(16'h0020, 1'b1);
    step_train(16'h0020, 1'b1);
    step_redirect(16'h0020);
    step_idle();
    n_total++;
    if (ram2_addr !== (BPRED ? 18'h00026 : 18'h00021) || bus.pred_taken_o !== BPRED)
      $display("FAIL bht_taken: got addr=%h pred=%b want addr=%h pred=%b",
               ram2_addr, bus.pred_taken_o, (BPRED ? 18'h00026 : 18'h00021), BPRED);
    else n_pass++;
    step_train(16'h0020, 1'b0);
    step_train(16'h0020, 1'b0);
    step_redirect(16'h0020);
    step_idle();
    n_total++;
    if (ram2_addr !== 18'h00021 || bus.pred_taken_o !== 1'b0)
      $display("FAIL bht_not_taken: got addr=%h pred=%b want addr=00021 pred=0",
               ram2_addr, bus.pred_taken_o);
    else n_pass++;
  endtask

  task automatic test_hold_redirect_flush();
    logic [67:0] snap;
    mem[16'h0100] = 16'h4321;
    step_idle();
    snap = exp_vec();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    n_total++;
    if (dut_vec() !== snap)
      $display("FAIL hold_freeze1: got %h want %h", dut_vec(), snap);
    else n_pass++;
    step(1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 0, 1'b0);
    n_total++;
    if (ram2_addr !== 18'h00100 || bus.instr_o !== 16'h0800 || bus.valid_o !== 1'b0 ||
        bus.pc_o !== 16'h0000)
      $display("FAIL hold_redir_flush: got addr=%h instr=%h valid=%b epc=%h want addr=00100 instr=0800 valid=0 epc=0000",
               ram2_addr, bus.instr_o, bus.valid_o, bus.pc_o);
    else n_pass++;
    snap = exp_vec();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    n_total++;
    if (dut_vec() !== snap)
      $display("FAIL hold_freeze3: got %h want %h", dut_vec(), snap);
    else n_pass++;
    step_idle();
    n_total++;
    if (bus.instr_o !== 16'h4321 || bus.pc_o !== 16'h0100 || bus.valid_o !== 1'b1 ||
        ram2_addr !== 18'h00101)
      $display("FAIL hold_release: got instr=%h epc=%h valid=%b addr=%h want instr=4321 epc=0100 valid=1 addr=00101",
               bus.instr_o, bus.pc_o, bus.valid_o, ram2_addr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 16'h0800;
    step_redirect(16'hFFFF);
    step_idle();
    n_total++;
    if (ram2_addr !== 18'h00000 || bus.pc_o !== 16'hFFFF || bus.pcplus1_o !== 16'h0000)
      $display("FAIL wrap_seq: got addr=%h epc=%h pc1=%h want addr=00000 epc=ffff pc1=0000",
               ram2_addr, bus.pc_o, bus.pcplus1_o);
    else n_pass++;
    mem[16'hFFF0] = 16'h101F;
    step_redirect(16'hFFF0);
    step_idle();
    n_total++;
    if (ram2_addr !== (BPRED ? 18'h00010 : 18'h0FFF1))
      $display("FAIL wrap_target: got addr=%h want %h", ram2_addr,
               (BPRED ? 18'h00010 : 18'h0FFF1));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step_train(16'h0020, 1'b1);
    step_train(16'h0020, 1'b1);
    step_idle();
    #3;
    rst = 1'b1;
    #1;
    n_total++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL async_reset: got %h want %h", dut_vec(), RESET_VEC);
    else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL async_reset_hold: got %h want %h", dut_vec(), RESET_VEC);
    else n_pass++;
    step_redirect(16'h0020);
    step_idle();
    n_total++;
    if (ram2_addr !== 18'h00021 || bus.pred_taken_o !== 1'b0)
      $display("FAIL async_reset_bht: got addr=%h pred=%b want addr=00021 pred=0",
               ram2_addr, bus.pred_taken_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      case ($urandom_range(5))
        0: w[15:11] = 5'b00010;
        1: w[15:11] = 5'b00100;
        2: w[15:11] = 5'b00101;
        3: w[15:11] = 5'b01100;
        default: ;
      endcase
      mem[i] = w;
    end
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0,
           $urandom_range(65535), $urandom_range(2) == 0,
           ($urandom_range(1) == 0) ? m_pc : $urandom_range(65535), $urandom_range(1) == 1);
      n_total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random_%0d: got %h want %h", c, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hold_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 16'h0;
    bus.bht_upd_i = 1'b0; bus.bht_upd_pc_i = 16'h0; bus.bht_taken_i = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0800;
    model_reset();
    test_reset();
    test_sequential();
    test_branch_b();
    test_bht_train();
    test_hold_redirect_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the zzcpu pipeline, directly upstream of the `id` decoder. Holds the program counter, drives the instruction SRAM (Ram2) read port, and predicts conditional and unconditional PC-relative branches with a 2-bit branch history table. It also owns the IF/ID pipeline register that feeds `instr`, `epc` and `pcplus1` into ID, with stall, flush and redirect control from the hazard unit.

## Interface
Parameters:
- `PC_RESET`, 16'h0000, PC value loaded on reset.
- `BHT_IDX_W`, 4, BHT index width; the table has 2^BHT_IDX_W entries indexed by `pc[BHT_IDX_W-1:0]`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `hold_i`, in, 1: stall; PC and IF/ID keep their values.
- `flush_i`, in, 1: load a NOP bubble into IF/ID.
- `redirect_i`, in, 1: jump, jr or mispredict correction resolved in ID.
- `redirect_pc_i`, in, 16: next PC when `redirect_i` is asserted.
- `bht_upd_i`, in, 1: train the BHT.
- `bht_upd_pc_i`, in, 16: PC of the resolved branch.
- `bht_taken_i`, in, 1: actual branch outcome.
- `instr_o`, out, 16: IF/ID instruction.
- `pc_o`, out, 16: IF/ID PC of `instr_o` (the epc).
- `pcplus1_o`, out, 16: IF/ID PC+1.
- `pred_taken_o`, out, 1: IF/ID prediction for `instr_o`.
- `valid_o`, out, 1: 0 marks the IF/ID slot as a bubble.
- `Ram2Addr`, out, 18: SRAM address.
- `Ram2Data`, inout, 16: SRAM data. Always high-Z from this block.
- `Ram2OE`, `Ram2WE`, `Ram2EN`, out, 1 each: active-low SRAM controls.

## Operation
- SRAM is read-only from this block:
  - `Ram2EN`=0, `Ram2OE`=0, `Ram2WE`=1 at all times, reset included.
  - `Ram2Addr` = {2'b00, pc}, combinational from the PC register.
  - The fetched word is `Ram2Data`, sampled at the rising edge.
- Predecode of the fetched word (opcode = bits [15:11]):
  - B 00010: target = pc+1+sext(imm11); always predicted taken.
  - BEQZ 00100, BNEZ 00101: target = pc+1+sext(imm8); prediction from BHT.
  - BTEQZ/BTNEZ 01100 with bits [10:8] = 000/001: target = pc+1+sext(imm8); prediction from BHT.
  - Anything else: not a branch, never predicted taken.
- Next-PC priority, highest first:
  - `rst`: PC_RESET.
  - `redirect_i`: `redirect_pc_i`.
  - `hold_i`: pc unchanged.
  - Predicted taken: target.
  - Otherwise: pc+1.
- All PC arithmetic is 16-bit modulo; 16'hFFFF+1 = 16'h0000, and targets wrap the same way.
- IF/ID update priority, highest first:
  - `rst`, or `flush_i`: instr=16'h0800 (NOP), pc=0, pcplus1=0, pred=0, valid=0.
  - `hold_i`: unchanged.
  - Otherwise: capture fetched word, pc, pc+1, prediction; valid=1.
- `redirect_i` alone does not squash IF/ID. The hazard unit asserts `flush_i` in the same cycle when squashing is needed.
- `redirect_i` together with `hold_i`: PC takes the redirect and IF/ID holds.
- BHT:
  - 2-bit saturating counters, reset to 01 (weakly not-taken); predict taken when bit[1]=1.
  - On `bht_upd_i`: counter at `bht_upd_pc_i` increments (saturating at 11) if taken, else decrements (saturating at 00).
  - Read-during-write to the same index returns the old value; the new value is visible the next cycle.

## Timing
- Fetch latency is one cycle: the word at PC N appears on `instr_o` after the edge that advances PC past N.
- Redirect penalty: `redirect_pc_i` is on `Ram2Addr` the cycle after the asserting edge. Its instruction reaches `instr_o` one edge later.
- A predicted-taken branch costs zero bubbles; the target is fetched the cycle after the branch.
- Reset mid-operation clears PC, IF/ID and BHT immediately (asynchronous). The first fetch from PC_RESET starts on the first edge after `rst` deasserts.

## Configuration
- `FETCH_BPRED_EN` defined: BHT and predecode are present, as described above.
- Not defined: no BHT storage. `pred_taken_o`=0 always, the next PC is pc+1 unless redirected or held, and `bht_upd_*` are ignored. B is then also resolved by ID through `redirect_i`.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_B, OP_BEQZ, OP_BNEZ, OP_BTEQZ_GRP);
  - `INSTR_NOP` = 16'h0800;
  - BHT counter encodings (SNT=00, WNT=01, WT=10, ST=11);
  - a `sext8`/`sext11` helper.
- One sub-module, `branch_history_table`: index in, prediction out, update port, async reset. It is instantiated only under `FETCH_BPRED_EN`.

## Test plan
- Reset release with SRAM words 0x0800 sequential: `Ram2Addr` steps 0,1,2,…; `instr_o` lags by one cycle; `valid_o` goes 0→1; `Ram2OE`=0, `Ram2WE`=1, `Ram2EN`=0 throughout.
- Word 0x1005 (B +5) at PC 0x0010: next `Ram2Addr`=0x0016; `pred_taken_o`=1 with `pc_o`=0x0010.
- BEQZ at 0x0020, trained by two `bht_upd_i` taken: the first fetch after training predicts 0x0021+imm. Training not-taken twice returns to predicting pc+1.
- `hold_i` for 3 cycles, with `redirect_i` to 0x0100 and `flush_i` in the middle cycle:
  - PC becomes 0x0100 after that edge;
  - `instr_o`=0x0800 and `valid_o`=0 after the flush;
  - IF/ID stays frozen while only `hold_i` is high.
- PC 0xFFFF, sequential fetch: next `Ram2Addr`=0x00000.
- `rst` pulsed asynchronously between edges: outputs clear immediately and PC returns to PC_RESET.
